crc_status_ctrl: RTL and testbench
==================================

// Module: crc_status_ctrl
// PURPOSE
//  Sequences the CRC result shown on the HEX1/HEX0 status display.
//  Tracks one frame check at a time: start -> wait for CRC verdict (with timeout) -> show result.
//  Drives the 2-bit status code consumed by the display decoder: 01=OK, 00=ERR, 11=blank.
//  Holds each result for a fixed time; errors blink. Keeps saturating OK/ERR tallies.
// PARAMETERS
//  HOLD_CYCLES     50_000_000  cycles a result stays on the display (1 s @ 50 MHz)
//  BLINK_HALF      12_500_000  half-period of the ERR blink, in cycles
//  TIMEOUT_CYCLES  100_000_000 max cycles in WAIT before the verdict is forced to ERR
//  CNT_W           27          timer width; must hold max(HOLD_CYCLES, TIMEOUT_CYCLES)
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous reset, active-high
//  start_in     in   1  1-cycle pulse: a new frame check has begun
//  crc_valid_in in   1  1-cycle pulse: CRC verdict available on crc_ok_in
//  crc_ok_in    in   1  verdict, sampled only when crc_valid_in=1 (1=OK, 0=ERR)
//  ack_in       in   1  1-cycle pulse: operator clears the display early
//  status_out   out  2  to display decoder: 01=OK, 00=ERR, 11=blank
//  busy_out     out  1  1 while in WAIT
//  ok_cnt_out   out  8  OK results shown since reset, saturates at 255
//  err_cnt_out  out  8  ERR results shown (incl. timeouts), saturates at 255
// BEHAVIOUR
//  Reset: state=IDLE, status_out=2'b11, busy_out=0, counters=0, timers=0.
//  All outputs are registered; they change on the clk edge after the input event.
//  FSM states: IDLE, WAIT, SHOW_OK, SHOW_ERR.
//  IDLE: status_out=11.
//   - crc_valid_in -> SHOW_OK/SHOW_ERR per crc_ok_in. A verdict without a prior start is accepted.
//   - else start_in -> WAIT.
//  WAIT: busy_out=1, status_out=11. Timer counts from 0.
//   - crc_valid_in -> SHOW_OK/SHOW_ERR. Takes priority over start_in in the same cycle.
//   - start_in alone -> restart the timer, stay in WAIT.
//   - timer reaches TIMEOUT_CYCLES-1 with no verdict -> SHOW_ERR.
//  Entering a SHOW state:
//   - the matching counter increments by 1 (no increment at 255).
//   - hold timer and blink timer clear to 0.
//  SHOW_OK: status_out=01 for exactly HOLD_CYCLES cycles, then IDLE.
//  SHOW_ERR: status_out=00 for the first BLINK_HALF cycles, then 11 for BLINK_HALF cycles,
//   repeating. Total duration is HOLD_CYCLES, then IDLE.
//  In either SHOW state:
//   - start_in -> WAIT immediately; the display blanks on the next cycle.
//   - crc_valid_in is ignored.
//   - ack_in -> IDLE.
//   - start_in wins over ack_in in the same cycle.
//  ack_in is ignored in IDLE and WAIT.
//  rst mid-operation returns everything to reset values on the next edge. Tallies are cleared.
//  Both counters never wrap.
// TESTING (sim params: HOLD_CYCLES=8, BLINK_HALF=2, TIMEOUT_CYCLES=16)
//  1. rst, start, valid with ok=1 three cycles later -> busy=1 for 3 cycles;
//     status=01 for 8 cycles then 11; ok_cnt=1.
//  2. start, valid with ok=0 -> status 00,00,11,11,00,00,11,11 then 11 (IDLE); err_cnt=1.
//  3. start, no verdict -> after 16 WAIT cycles status=00 blink begins; err_cnt=1; busy drops.
//  4. In SHOW_OK cycle 3: start+ack together -> WAIT (busy=1, status=11).
//     Same cycle crc_valid+start in WAIT -> verdict shown, start ignored.
//  5. 300 OK verdicts from IDLE, each followed by ack -> ok_cnt holds 255, err_cnt=0.
//  6. rst asserted mid-SHOW_ERR with err_cnt=5 -> next cycle status=11, busy=0, both counters 0.

Source files
------------

// File: rtl/crc_status_ctrl.sv
// crc_status_ctrl: sequences the CRC verdict on the HEX status display.
// One check at a time: start, wait for verdict (timeout), show result.
module crc_status_ctrl #(
  parameter int HOLD_CYCLES    = 50_000_000,
  parameter int BLINK_HALF     = 12_500_000,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int CNT_W          = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_in,
  input  logic       crc_valid_in,
  input  logic       crc_ok_in,
  input  logic       ack_in,
  output logic [1:0] status_out,
  output logic       busy_out,
  output logic [7:0] ok_cnt_out,
  output logic [7:0] err_cnt_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SHOW_OK,
    S_SHOW_ERR
  } state_t;

  localparam logic [CNT_W-1:0] L_TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_BLNK_LAST = CNT_W'(BLINK_HALF - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] w_timer_nxt;
  logic [CNT_W-1:0] r_blink;
  logic [CNT_W-1:0] w_blink_nxt;
  logic             r_phase;
  logic             w_phase_nxt;
  logic             w_ok_inc;
  logic             w_err_inc;
  logic [1:0]       w_status_nxt;
  logic [1:0]       r_status;
  logic             r_busy;
  logic [7:0]       r_ok;
  logic [7:0]       r_err;

  always_comb begin
    w_next      = r_state;
    w_timer_nxt = r_timer + 1'b1;
    w_blink_nxt = r_blink;
    w_phase_nxt = r_phase;
    w_ok_inc    = 1'b0;
    w_err_inc   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (crc_valid_in) begin
          w_ok_inc  = crc_ok_in;
          w_err_inc = !crc_ok_in;
        end else if (start_in) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (crc_valid_in) begin
          w_ok_inc  = crc_ok_in;
          w_err_inc = !crc_ok_in;
        end else if (start_in) begin
          w_timer_nxt = '0;
        end else if (r_timer == L_TO_LAST) begin
          w_err_inc = 1'b1;
        end
      end
      S_SHOW_OK, S_SHOW_ERR: begin
        if (r_blink == L_BLNK_LAST) begin
          w_blink_nxt = '0;
          w_phase_nxt = !r_phase;
        end else begin
          w_blink_nxt = r_blink + 1'b1;
        end
        if (start_in) begin
          w_next      = S_WAIT;
          w_timer_nxt = '0;
        end else if (ack_in || r_timer == L_HOLD_LAST) begin
          w_next      = S_IDLE;
          w_timer_nxt = '0;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // every entry into a SHOW state restarts hold and blink timing
    if (w_ok_inc || w_err_inc) begin
      w_next      = w_ok_inc ? S_SHOW_OK : S_SHOW_ERR;
      w_timer_nxt = '0;
      w_blink_nxt = '0;
      w_phase_nxt = 1'b0;
    end
  end

  always_comb begin
    w_status_nxt = 2'b11;
    unique case (w_next)
      S_SHOW_OK:  w_status_nxt = 2'b01;
      S_SHOW_ERR: w_status_nxt = w_phase_nxt ? 2'b11 : 2'b00;
      default:    w_status_nxt = 2'b11;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_blink  <= '0;
      r_phase  <= 1'b0;
      r_status <= 2'b11;
      r_busy   <= 1'b0;
      r_ok     <= '0;
      r_err    <= '0;
    end else begin
      r_state  <= w_next;
      r_timer  <= w_timer_nxt;
      r_blink  <= w_blink_nxt;
      r_phase  <= w_phase_nxt;
      r_status <= w_status_nxt;
      r_busy   <= (w_next == S_WAIT);
      if (w_ok_inc && r_ok != 8'hFF) r_ok <= r_ok + 8'd1;
      if (w_err_inc && r_err != 8'hFF) r_err <= r_err + 8'd1;
    end
  end

  assign status_out  = r_status;
  assign busy_out    = r_busy;
  assign ok_cnt_out  = r_ok;
  assign err_cnt_out = r_err;

endmodule

// File: tb/tb_crc_status_ctrl.sv
// tb_crc_status_ctrl: directed stimulus with a cycle-level reference model
// plus literal expectations that pin the model.
module tb_crc_status_ctrl;

  localparam int HOLD = 8;
  localparam int BLNK = 2;
  localparam int TOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_in;
  logic       crc_valid_in;
  logic       crc_ok_in;
  logic       ack_in;
  logic [1:0] status_out;
  logic       busy_out;
  logic [7:0] ok_cnt_out;
  logic [7:0] err_cnt_out;

  int n_checks = 0;
  int n_errors = 0;

  // model: 0=idle 1=wait 2=show ok 3=show err
  int m_mode = 0;
  int m_el   = 0;
  int m_ok   = 0;
  int m_err  = 0;

  crc_status_ctrl #(
    .HOLD_CYCLES(HOLD),
    .BLINK_HALF(BLNK),
    .TIMEOUT_CYCLES(TOUT),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_in(start_in),
    .crc_valid_in(crc_valid_in),
    .crc_ok_in(crc_ok_in),
    .ack_in(ack_in),
    .status_out(status_out),
    .busy_out(busy_out),
    .ok_cnt_out(ok_cnt_out),
    .err_cnt_out(err_cnt_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic m_show(input bit ok);
    m_mode = ok ? 2 : 3;
    m_el   = 0;
    if (ok) m_ok = (m_ok < 255) ? m_ok + 1 : 255;
    else m_err = (m_err < 255) ? m_err + 1 : 255;
  endtask

  task automatic m_update(input bit s, input bit v, input bit o,
                          input bit a, input bit r);
    if (r) begin
      m_mode = 0; m_el = 0; m_ok = 0; m_err = 0;
    end else if (m_mode == 0) begin
      if (v) m_show(o);
      else if (s) begin m_mode = 1; m_el = 0; end
    end else if (m_mode == 1) begin
      if (v) m_show(o);
      else if (s) m_el = 0;
      else begin
        m_el++;
        if (m_el >= TOUT) m_show(1'b0);
      end
    end else begin
      if (s) begin m_mode = 1; m_el = 0; end
      else if (a) begin m_mode = 0; m_el = 0; end
      else begin
        m_el++;
        if (m_el >= HOLD) begin m_mode = 0; m_el = 0; end
      end
    end
  endtask

  function automatic int m_status();
    if (m_mode == 2) return 1;
    if (m_mode == 3) return ((m_el / BLNK) % 2 == 1) ? 3 : 0;
    return 3;
  endfunction

  task automatic compare();
    chk("status", int'(status_out), m_status());
    chk("busy", int'(busy_out), (m_mode == 1) ? 1 : 0);
    chk("ok_cnt", int'(ok_cnt_out), m_ok);
    chk("err_cnt", int'(err_cnt_out), m_err);
  endtask

  task automatic step(input bit s, input bit v, input bit o,
                      input bit a, input bit r);
    start_in = s; crc_valid_in = v; crc_ok_in = o; ack_in = a; rst = r;
    @(posedge clk);
    m_update(s, v, o, a, r);
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  int exp_err_seq [9] = '{0, 0, 3, 3, 0, 0, 3, 3, 3};

  initial begin
    rst = 1; start_in = 0; crc_valid_in = 0; crc_ok_in = 0; ack_in = 0;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("reset_status", int'(status_out), 3);
    chk("reset_busy", int'(busy_out), 0);
    chk("reset_cnts", int'({ok_cnt_out, err_cnt_out}), 0);

    // 1: OK verdict three cycles after start
    step(1, 0, 0, 0, 0);
    chk("t1_busy0", int'(busy_out), 1);
    idle(2);
    chk("t1_busy2", int'(busy_out), 1);
    step(0, 1, 1, 0, 0);
    chk("t1_ok_cnt", int'(ok_cnt_out), 1);
    for (int i = 0; i < 7; i++) begin
      idle(1);
      chk("t1_hold", int'(status_out), 1);
    end
    idle(1);
    chk("t1_end", int'(status_out), 3);

    // 2: ERR blink pattern
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("t2_seq0", int'(status_out), exp_err_seq[0]);
    for (int i = 1; i < 9; i++) begin
      idle(1);
      chk("t2_seq", int'(status_out), exp_err_seq[i]);
    end
    chk("t2_err_cnt", int'(err_cnt_out), 1);

    // 3: timeout
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    idle(TOUT - 1);
    chk("t3_still_wait", int'(busy_out), 1);
    idle(1);
    chk("t3_status", int'(status_out), 0);
    chk("t3_busy", int'(busy_out), 0);
    chk("t3_err_cnt", int'(err_cnt_out), 1);
    idle(HOLD);

    // 4: start+ack in SHOW_OK, then valid+start in WAIT
    step(0, 1, 1, 0, 0);
    idle(2);
    step(1, 0, 0, 1, 0);
    chk("t4_busy", int'(busy_out), 1);
    chk("t4_status", int'(status_out), 3);
    step(1, 1, 0, 0, 0);
    chk("t4_verdict", int'(status_out), 0);
    chk("t4_busy_off", int'(busy_out), 0);
    step(0, 1, 1, 0, 0);
    chk("t4_valid_ignored", int'(status_out), 0);
    step(0, 0, 0, 1, 0);
    chk("t4_ack", int'(status_out), 3);

    // 5: OK tally saturation
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 300; i++) begin
      step(0, 1, 1, 0, 0);
      step(0, 0, 0, 1, 0);
    end
    chk("t5_ok_sat", int'(ok_cnt_out), 255);
    chk("t5_err", int'(err_cnt_out), 0);

    // 6: reset mid-SHOW_ERR
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0);
    end
    step(0, 1, 0, 0, 0);
    idle(2);
    chk("t6_err5", int'(err_cnt_out), 5);
    step(0, 0, 0, 0, 1);
    chk("t6_status", int'(status_out), 3);
    chk("t6_busy", int'(busy_out), 0);
    chk("t6_cnts", int'({ok_cnt_out, err_cnt_out}), 0);

    // pseudo-random mix against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
           $urandom_range(0, 199) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
